// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU operation sequencer slice.
//   DATA_W      - datapath width of the shared ALU
//   OP_*        - 3-bit ALU opcodes (passed through undecoded by the sequencer)
//   seq_state_t - sequencer FSM state encoding
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: bundles the two requester ports, the ALU-facing
// operand/result bus and the response port of the sequencer.
//   slave  modport - the sequencer's view (consumes requests, drives the ALU
//                    operands and the response)
//   master modport - the surrounding glue's view (requesters, ALU, consumer)
interface alu_op_sequencer_if;
  import alu_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [2:0]        req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [2:0]        req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_carry;
  logic              rsp_zero;

  logic              busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result, alu_carry, alu_zero,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result, alu_carry, alu_zero,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero,
    input  busy
  );

endinterface

// File: rtl/alu_op_sequencer_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter.
//   clk, rst        - clock and synchronous active-high reset
//   enable          - arbitration allowed this cycle (sequencer idle)
//   valid0, valid1  - requester valids
//   grant0, grant1  - combinational one-hot grants; a grant is also the accept
// The priority pointer flips to the other requester on every grant, so a
// requester that keeps valid asserted can never be starved.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  logic rr_ptr;

  // rr_ptr only matters when both requesters are valid.
  assign grant0 = enable & valid0 & (~valid1 | ~rr_ptr);
  assign grant1 = enable & valid1 & (~valid0 |  rr_ptr);

  // After serving one requester, prefer the other one next time.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (grant0) begin
      rr_ptr <= 1'b1;
    end else if (grant1) begin
      rr_ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: shares one ALU between two requesters.
//   clk, rst - clock and synchronous active-high reset
//   bus      - alu_op_sequencer_if.slave: req0/req1 valid/ready operation
//              ports, ALU operand/result bus, rsp valid/ready response port
//              and the busy flag
// A granted operation is latched onto the ALU operands, held for ALU_LATENCY
// cycles, and the ALU outputs are then captured into the response registers,
// which stay stable until the consumer takes them.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = 1,
  parameter int CNT_W       = 4
) (
  input logic clk,
  input logic rst,
  alu_op_sequencer_if.slave bus
);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             idle;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             capture;
  logic             release_rsp;

  assign idle = (state == IDLE);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .enable (idle),
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.busy       = ~idle;

  // Next-state logic. The counter reaching 1 marks the last edge the
  // operands must be held, so the ALU outputs are captured on that edge.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    case (state)
      IDLE: begin
        if (grant0 | grant1) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (cnt == CNT_W'(1)) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_valid && bus.rsp_ready) begin
          release_rsp = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and latency down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= CNT_W'(ALU_LATENCY);
      end else if (state == EXEC) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Operand and response registers. Operands only change on accept so the
  // ALU inputs do not toggle while idle or waiting on the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.alu_op     <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_carry  <= 1'b0;
      bus.rsp_zero   <= 1'b0;
    end else begin
      if (accept) begin
        bus.alu_op <= grant1 ? bus.req1_op : bus.req0_op;
        bus.alu_a  <= grant1 ? bus.req1_a  : bus.req0_a;
        bus.alu_b  <= grant1 ? bus.req1_b  : bus.req0_b;
        bus.rsp_id <= grant1;
      end
      if (capture) begin
        bus.rsp_result <= bus.alu_result;
        bus.rsp_carry  <= bus.alu_carry;
        bus.rsp_zero   <= bus.alu_zero;
        bus.rsp_valid  <= 1'b1;
      end else if (release_rsp) begin
        bus.rsp_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: drives two sequencer instances (ALU_LATENCY 1 and 4)
// with identical requester/consumer stimulus and compares every output each
// cycle against a transaction-level model of the sharing rules.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_op_sequencer_if bus_l1 ();
  alu_op_sequencer_if bus_l4 ();

  alu_op_sequencer #(.ALU_LATENCY(1), .CNT_W(4)) dut_l1 (
    .clk (clk),
    .rst (rst),
    .bus (bus_l1)
  );

  alu_op_sequencer #(.ALU_LATENCY(4), .CNT_W(4)) dut_l4 (
    .clk (clk),
    .rst (rst),
    .bus (bus_l4)
  );

  // Behavioural ALU: returns {carry, zero, result}.
  function automatic logic [9:0] alu_ref(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic       c;
    w = '0;
    r = '0;
    c = 1'b0;
    case (op)
      OP_ADD:  begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; end
      OP_SUB:  begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SHL:  begin r = {a[6:0], 1'b0}; c = a[7]; end
      OP_SHR:  begin r = {1'b0, a[7:1]}; c = a[0]; end
      default: r = a;
    endcase
    return {c, (r == 8'h00), r};
  endfunction

  assign {bus_l1.alu_carry, bus_l1.alu_zero, bus_l1.alu_result} =
         alu_ref(bus_l1.alu_op, bus_l1.alu_a, bus_l1.alu_b);
  assign {bus_l4.alu_carry, bus_l4.alu_zero, bus_l4.alu_result} =
         alu_ref(bus_l4.alu_op, bus_l4.alu_a, bus_l4.alu_b);

  // Current stimulus.
  logic       cur_rst;
  logic       cur_v0, cur_v1, cur_rr;
  logic [2:0] cur_op0, cur_op1;
  logic [7:0] cur_a0, cur_b0, cur_a1, cur_b1;

  // Reference model state, one slot per instance (0: latency 1, 1: latency 4).
  bit         m_busy[2];
  bit         m_rspv[2];
  int         m_pref[2];
  bit         m_owner[2];
  logic [2:0] m_op[2];
  logic [7:0] m_a[2];
  logic [7:0] m_b[2];
  logic [9:0] m_rsp[2];
  int         m_elapsed[2];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int latOf(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Which requester the sharing rules favour right now (-1: none).
  function automatic int winner(int k);
    if (cur_v0 && cur_v1) return m_pref[k];
    if (cur_v0) return 0;
    if (cur_v1) return 1;
    return -1;
  endfunction

  task automatic driveBuses();
    rst               = cur_rst;
    bus_l1.req0_valid = cur_v0;  bus_l4.req0_valid = cur_v0;
    bus_l1.req0_op    = cur_op0; bus_l4.req0_op    = cur_op0;
    bus_l1.req0_a     = cur_a0;  bus_l4.req0_a     = cur_a0;
    bus_l1.req0_b     = cur_b0;  bus_l4.req0_b     = cur_b0;
    bus_l1.req1_valid = cur_v1;  bus_l4.req1_valid = cur_v1;
    bus_l1.req1_op    = cur_op1; bus_l4.req1_op    = cur_op1;
    bus_l1.req1_a     = cur_a1;  bus_l4.req1_a     = cur_a1;
    bus_l1.req1_b     = cur_b1;  bus_l4.req1_b     = cur_b1;
    bus_l1.rsp_ready  = cur_rr;  bus_l4.rsp_ready  = cur_rr;
  endtask

  task automatic checkInst(input int k);
    logic       r0, r1, bz, rv, rid;
    logic [2:0] op;
    logic [7:0] a, b;
    logic [9:0] rsp;
    string      p;
    int         w;
    if (k == 0) begin
      r0 = bus_l1.req0_ready; r1 = bus_l1.req1_ready; bz = bus_l1.busy;
      rv = bus_l1.rsp_valid;  rid = bus_l1.rsp_id;
      op = bus_l1.alu_op; a = bus_l1.alu_a; b = bus_l1.alu_b;
      rsp = {bus_l1.rsp_carry, bus_l1.rsp_zero, bus_l1.rsp_result};
    end else begin
      r0 = bus_l4.req0_ready; r1 = bus_l4.req1_ready; bz = bus_l4.busy;
      rv = bus_l4.rsp_valid;  rid = bus_l4.rsp_id;
      op = bus_l4.alu_op; a = bus_l4.alu_a; b = bus_l4.alu_b;
      rsp = {bus_l4.rsp_carry, bus_l4.rsp_zero, bus_l4.rsp_result};
    end
    p = $sformatf("L%0d", latOf(k));
    w = winner(k);
    checkOutput({p, " req0_ready"}, 32'(r0), 32'(!m_busy[k] && w == 0));
    checkOutput({p, " req1_ready"}, 32'(r1), 32'(!m_busy[k] && w == 1));
    checkOutput({p, " busy"}, 32'(bz), 32'(m_busy[k]));
    checkOutput({p, " rsp_valid"}, 32'(rv), 32'(m_rspv[k]));
    checkOutput({p, " rsp_id"}, 32'(rid), 32'(m_owner[k]));
    checkOutput({p, " rsp_carry_zero_result"}, 32'(rsp), 32'(m_rsp[k]));
    checkOutput({p, " alu_op_a_b"}, 32'({op, a, b}), 32'({m_op[k], m_a[k], m_b[k]}));
  endtask

  // Advance the model across the coming rising edge.
  task automatic stepModel(input int k);
    int w;
    w = winner(k);
    if (cur_rst) begin
      m_busy[k] = 0; m_rspv[k] = 0; m_pref[k] = 0; m_owner[k] = 0;
      m_op[k] = '0; m_a[k] = '0; m_b[k] = '0; m_rsp[k] = '0; m_elapsed[k] = 0;
    end else if (!m_busy[k]) begin
      if (w >= 0) begin
        m_busy[k]    = 1;
        m_owner[k]   = (w == 1);
        m_pref[k]    = 1 - w;
        m_op[k]      = (w == 1) ? cur_op1 : cur_op0;
        m_a[k]       = (w == 1) ? cur_a1  : cur_a0;
        m_b[k]       = (w == 1) ? cur_b1  : cur_b0;
        m_elapsed[k] = 0;
      end
    end else if (!m_rspv[k]) begin
      m_elapsed[k]++;
      if (m_elapsed[k] == latOf(k)) begin
        m_rspv[k] = 1;
        m_rsp[k]  = alu_ref(m_op[k], m_a[k], m_b[k]);
      end
    end else if (cur_rr) begin
      m_rspv[k] = 0;
      m_busy[k] = 0;
    end
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic applyStimulus(input logic r, input logic v0, input logic [2:0] op0,
                               input logic [7:0] a0, input logic [7:0] b0,
                               input logic v1, input logic [2:0] op1,
                               input logic [7:0] a1, input logic [7:0] b1,
                               input logic rr);
    @(negedge clk);
    cur_rst = r;
    cur_v0 = v0; cur_op0 = op0; cur_a0 = a0; cur_b0 = b0;
    cur_v1 = v1; cur_op1 = op1; cur_a1 = a1; cur_b1 = b1;
    cur_rr = rr;
    driveBuses();
    #1;
    checkInst(0);
    checkInst(1);
    stepModel(0);
    stepModel(1);
  endtask

  task automatic idleCycles(input int n, input logic rr);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, rr);
    end
  endtask

  initial begin
    cur_rst = 1'b1;
    cur_v0 = 0; cur_op0 = 0; cur_a0 = 0; cur_b0 = 0;
    cur_v1 = 0; cur_op1 = 0; cur_a1 = 0; cur_b1 = 0;
    cur_rr = 0;
    driveBuses();
    for (int k = 0; k < 2; k++) begin
      stepModel(k);
    end
    repeat (2) @(posedge clk);

    // Reset held for two cycles, then idle with no valids.
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    idleCycles(2, 1'b0);

    // Single ADD from requester 0, response held until released.
    applyStimulus(1'b0, 1'b1, OP_ADD, 8'h0F, 8'h01, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    idleCycles(6, 1'b0);
    checkOutput("L1 add rsp_valid", 32'(bus_l1.rsp_valid), 32'd1);
    checkOutput("L1 add rsp_result", 32'(bus_l1.rsp_result), 32'h10);
    checkOutput("L1 add rsp_carry", 32'(bus_l1.rsp_carry), 32'd0);
    checkOutput("L1 add rsp_zero", 32'(bus_l1.rsp_zero), 32'd0);
    checkOutput("L1 add rsp_id", 32'(bus_l1.rsp_id), 32'd0);
    idleCycles(2, 1'b1);

    // Contention: both requesters valid continuously.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, OP_SUB, 8'h05, 8'h05, 1'b1, OP_XOR, 8'hAA, 8'h55, 1'b1);
    end
    idleCycles(8, 1'b1);

    // Backpressure with requester 1 waiting, then release.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, OP_OR, 8'h30, 8'h03, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, OP_SHL, 8'h81, 8'h00, 1'b1);
    end
    idleCycles(8, 1'b1);

    // Latency 4: FF+01 wraps to zero with carry.
    applyStimulus(1'b0, 1'b1, OP_ADD, 8'hFF, 8'h01, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    idleCycles(4, 1'b0);
    checkOutput("L4 rsp_valid before latency", 32'(bus_l4.rsp_valid), 32'd0);
    idleCycles(1, 1'b0);
    checkOutput("L4 rsp_valid at latency", 32'(bus_l4.rsp_valid), 32'd1);
    checkOutput("L4 wrap rsp_flags_result",
                32'({bus_l4.rsp_carry, bus_l4.rsp_zero, bus_l4.rsp_result}), 32'h300);
    idleCycles(2, 1'b1);

    // Reset during the second EXEC cycle drops the operation.
    applyStimulus(1'b0, 1'b1, OP_PASS, 8'h5A, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    idleCycles(1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    idleCycles(6, 1'b0);
    checkOutput("L4 rsp_valid after mid-op reset", 32'(bus_l4.rsp_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, OP_AND, 8'hF0, 8'h3C, 1'b1);
    idleCycles(8, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom), 8'($urandom),
                    1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Controller that shares the team's single 8-bit ALU between two requesters (e.g. the host-input path and the internal program sequencer).
- Arbitrates round-robin, latches the winning operands, holds them on the ALU for a fixed latency, then returns the captured result through a valid/ready response port.
- Sits between the top-level I/O glue and the simple 8-bit ALU; the ALU itself stays purely combinational or fixed-latency.

Parameters:
- ALU_LATENCY, 1, cycles operands must be held before alu_result is sampled; legal range 1..15.
- CNT_W, 4, width of the latency down-counter; must hold ALU_LATENCY.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  3  ALU opcode
- req0_a  in  8  operand A
- req0_b  in  8  operand B
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
- alu_op  out  3  opcode driven to the ALU
- alu_a  out  8  operand A to the ALU
- alu_b  out  8  operand B to the ALU
- alu_result  in  8  ALU result
- alu_carry  in  1  ALU carry/borrow flag
- alu_zero  in  1  ALU zero flag
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  requester index that owns the response
- rsp_result  out  8  captured result
- rsp_carry  out  1  captured carry
- rsp_zero  out  1  captured zero
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst=1 at a rising edge): state goes to IDLE. rr_ptr=0 (requester 0 preferred). Counter=0. All registered outputs are 0: alu_*, rsp_*, busy.
- Reset takes priority over every other event. Mid-operation, an in-flight op is dropped and no response is ever produced for it.
- States: IDLE, EXEC, RESP.
- IDLE arbitration:
  - grant0 = req0_valid & (~req1_valid | ~rr_ptr).
  - grant1 = req1_valid & (~req0_valid | rr_ptr).
  - reqN_ready = (state==IDLE) & grantN. This is combinational, and at most one ready is high.
- Accept edge (valid&ready):
  - Latch op, a and b onto alu_op/alu_a/alu_b.
  - Latch the requester index into rsp_id.
  - rr_ptr becomes the other requester.
  - Counter loads ALU_LATENCY.
  - Next state is EXEC.
- EXEC:
  - alu_op/alu_a/alu_b stay constant.
  - Counter decrements each cycle.
  - On the edge where counter==1: capture alu_result/alu_carry/alu_zero into rsp_*, set rsp_valid=1, and go to RESP.
  - rsp_valid therefore rises exactly ALU_LATENCY edges after the accept edge.
- RESP:
  - All rsp_* are held stable while rsp_valid & ~rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid is cleared and the state goes to IDLE.
  - No new request is accepted in the same cycle.
  - Throughput is one operation per ALU_LATENCY+2 cycles minimum.
- alu_* keep their last values in IDLE and RESP, so there is no gratuitous toggling.
- Only one requester valid: it wins regardless of rr_ptr.
- Both requesters valid: the one selected by rr_ptr wins. The loser's ready stays low and it must keep valid asserted.
- A requester may drop valid while not granted; the sequencer keeps no memory of it.
- rsp_ready high while rsp_valid is low is ignored.
- Opcodes are passed through without decoding. The sequencer is width-exact: no arithmetic on data.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams: OP_ADD=3'd0, OP_SUB=3'd1, OP_AND=3'd2, OP_OR=3'd3, OP_XOR=3'd4, OP_SHL=3'd5, OP_SHR=3'd6, OP_PASS=3'd7;
  - state encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2;
  - DATA_W=8.
- One sub-module, rr_arbiter2. It is a combinational two-way grant computed from the valids and rr_ptr, with the rr_ptr register and update-on-accept inside it.

Test Plan:
- Reset, then idle: assert rst for 2 cycles -> all outputs 0, busy=0, no ready while both valids are low.
- Single op, ALU_LATENCY=1: req0 ADD a=8'h0F b=8'h01 -> req0_ready=1 for one cycle; alu_a=8'h0F, alu_b=8'h01; rsp_valid one edge later with rsp_result=8'h10, carry=0, zero=0, rsp_id=0.
- Round-robin contention: both valid continuously with req0 SUB 5-5 and req1 XOR AA^55 -> grants in order 0,1,0,1; responses 8'h00 with zero=1 (id 0) and 8'hFF (id 1); no requester is granted twice in a row.
- Backpressure: hold rsp_ready=0 for 5 cycles with req1 waiting -> rsp_* stable, req1_ready stays 0, busy=1. Release -> req1 is accepted on the cycle after the handshake.
- Latency parameter, ALU_LATENCY=4: accept at edge E -> alu_* stable for 4 cycles, rsp_valid rises at E+4. An ALU model with 4-cycle delay gives ADD 8'hFF+8'h01 -> result 8'h00, carry=1, zero=1.
- Reset mid-EXEC: rst asserted during the 2nd EXEC cycle -> no rsp_valid afterwards, state IDLE, rr_ptr=0; the next req1-only request is accepted normally.
